idli_sqi_ctrl: RTL and testbench

Parametrised SQI memory controller that sequences command, address, dummy and data phases for `SQI_NUM` serial-quad SRAMs driven in lockstep. Each data beat carries one nibble per memory, so a beat is `SQI_NUM*4` bits wide. Memory 0 holds the low nibble (`SQI_MEM_LO`) and memory 1 the next nibble (`SQI_MEM_HI`); higher indices continue upward. The block sits between the fetch/LSU request arbiter and the SQI pads. It adds burst length, write support and flow control by clock gating.

---
 rtl/idli_sqi_ctrl.sv | 175 +++++++++++++++++
 tb/tb_idli_sqi_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl.sv
// SQI memory controller: sequences command, address, dummy and data phases for
// SQI_NUM quad SRAMs in lockstep, with flow control by gating SCK.
module idli_sqi_ctrl #(
  parameter int unsigned SQI_NUM      = 2,
  parameter int unsigned ADDR_NIBBLES = 6,
  parameter int unsigned DUMMY_CYC    = 2,
  parameter int unsigned LEN_W        = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_vld,
  output logic                      o_req_rdy,
  input  logic                      i_req_wr,
  input  logic [4*ADDR_NIBBLES-1:0] i_req_addr,
  input  logic [LEN_W-1:0]          i_req_len,
  output logic                      o_rd_vld,
  output logic [SQI_NUM*4-1:0]      o_rd_data,
  input  logic                      i_rd_rdy,
  input  logic                      i_wr_vld,
  input  logic [SQI_NUM*4-1:0]      i_wr_data,
  output logic                      o_wr_rdy,
  output logic                      o_sqi_cs_n,
  output logic                      o_sqi_sck_en,
  output logic                      o_sqi_oe,
  output logic [SQI_NUM*4-1:0]      o_sqi_dout,
  input  logic [SQI_NUM*4-1:0]      i_sqi_din
);

  localparam int unsigned AW = 4 * ADDR_NIBBLES;
  localparam logic [7:0] AddrLast  = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0] DummyLast = 8'(DUMMY_CYC - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StEnd} state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [7:0]        phase_q, phase_d;
  logic              beat_xfer;
  logic [3:0]        cmd_nib;

  assign beat_xfer = (state_q == StData) && (wr_q ? i_wr_vld : i_rd_rdy);
  // Opcode 0x03 (read) or 0x02 (write), high nibble first.
  assign cmd_nib   = phase_q[0] ? {3'b001, ~wr_q} : 4'h0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    phase_d = phase_q + 8'd1;
    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        if (i_req_vld) begin
          wr_d    = i_req_wr;
          addr_d  = i_req_addr;
          len_d   = i_req_len;
          beat_d  = '0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (phase_q == 8'd1) begin
          phase_d = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        // Shift so the next nibble to send is always on top.
        addr_d = addr_q << 4;
        if (phase_q == AddrLast) begin
          phase_d = '0;
          state_d = (wr_q || DUMMY_CYC == 0) ? StData : StDummy;
        end
      end
      StDummy: begin
        if (phase_q == DummyLast) begin
          phase_d = '0;
          state_d = StData;
        end
      end
      StData: begin
        phase_d = '0;
        if (beat_xfer) begin
          if (beat_q == len_q) state_d = StEnd;
          else                 beat_d  = beat_q + LEN_W'(1);
        end
      end
      StEnd: begin
        phase_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_rdy    = 1'b0;
    o_rd_vld     = 1'b0;
    o_rd_data    = '0;
    o_wr_rdy     = 1'b0;
    o_sqi_cs_n   = 1'b1;
    o_sqi_sck_en = 1'b0;
    o_sqi_oe     = 1'b0;
    o_sqi_dout   = '0;
    unique case (state_q)
      StIdle: o_req_rdy = 1'b1;
      StCmd: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        o_sqi_dout   = {SQI_NUM{cmd_nib}};
      end
      StAddr: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        o_sqi_dout   = {SQI_NUM{addr_q[AW-1 -: 4]}};
      end
      StDummy: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
      end
      StData: begin
        o_sqi_cs_n = 1'b0;
        if (wr_q) begin
          o_wr_rdy     = 1'b1;
          o_sqi_oe     = 1'b1;
          o_sqi_dout   = i_wr_data;
          o_sqi_sck_en = i_wr_vld;
        end else begin
          o_rd_vld     = 1'b1;
          o_rd_data    = i_sqi_din;
          o_sqi_sck_en = i_rd_rdy;
        end
      end
      StEnd: ;
      default: ;
    endcase
    // Reset overrides everything so outputs are defined before the first edge.
    if (i_rst) begin
      o_req_rdy    = 1'b0;
      o_rd_vld     = 1'b0;
      o_rd_data    = '0;
      o_wr_rdy     = 1'b0;
      o_sqi_cs_n   = 1'b1;
      o_sqi_sck_en = 1'b0;
      o_sqi_oe     = 1'b0;
      o_sqi_dout   = '0;
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Directed bench for idli_sqi_ctrl: default build plus a single-memory,
// zero-dummy build, checked cycle by cycle against hand-derived timing.
module tb_idli_sqi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_vec = 0;
  int          n_err = 0;

  // Default build (SQI_NUM=2, ADDR_NIBBLES=6, DUMMY_CYC=2)
  logic        req_vld = 0, req_wr = 0, req_rdy;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic        rd_vld, rd_rdy = 0, wr_vld = 0, wr_rdy;
  logic [7:0]  rd_data, wr_data = '0, dout, din = '0;
  logic        cs_n, sck_en, oe;

  // Single-memory build (SQI_NUM=1, DUMMY_CYC=0)
  logic        req_vld1 = 0, req_wr1 = 0, req_rdy1;
  logic [23:0] req_addr1 = '0;
  logic [7:0]  req_len1 = '0;
  logic        rd_vld1, rd_rdy1 = 0, wr_vld1 = 0, wr_rdy1;
  logic [3:0]  rd_data1, wr_data1 = '0, dout1, din1 = '0;
  logic        cs_n1, sck_en1, oe1;

  always #5 clk = ~clk;

  idli_sqi_ctrl u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_vld(req_vld), .o_req_rdy(req_rdy), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_len(req_len),
    .o_rd_vld(rd_vld), .o_rd_data(rd_data), .i_rd_rdy(rd_rdy),
    .i_wr_vld(wr_vld), .i_wr_data(wr_data), .o_wr_rdy(wr_rdy),
    .o_sqi_cs_n(cs_n), .o_sqi_sck_en(sck_en), .o_sqi_oe(oe),
    .o_sqi_dout(dout), .i_sqi_din(din)
  );

  idli_sqi_ctrl #(.SQI_NUM(1), .ADDR_NIBBLES(6), .DUMMY_CYC(0), .LEN_W(8)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_vld(req_vld1), .o_req_rdy(req_rdy1), .i_req_wr(req_wr1),
    .i_req_addr(req_addr1), .i_req_len(req_len1),
    .o_rd_vld(rd_vld1), .o_rd_data(rd_data1), .i_rd_rdy(rd_rdy1),
    .i_wr_vld(wr_vld1), .i_wr_data(wr_data1), .o_wr_rdy(wr_rdy1),
    .o_sqi_cs_n(cs_n1), .o_sqi_sck_en(sck_en1), .o_sqi_oe(oe1),
    .o_sqi_dout(dout1), .i_sqi_din(din1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read of 0x012345, len 3; optionally stall beat stall_beat for stall_n cycles.
  // Cycle 0 is the current (idle) cycle.
  task automatic run_read(input int stall_beat, input int stall_n);
    int beats = 0;
    int s = 0;
    logic [3:0] n;
    req_vld = 1; req_wr = 0; req_addr = 24'h012345; req_len = 8'd3; rd_rdy = 1;
    #1 check("rd c0 req_rdy", req_rdy, 1);
    for (int c = 1; c <= 16 + stall_n; c++) begin
      tick;
      req_vld = 0;
      din = 8'h40 + 8'(c);
      rd_rdy = 1;
      if (c >= 11 && beats == stall_beat && s < stall_n) begin
        rd_rdy = 0;
        s++;
      end
      #1;
      if (c <= 2) begin
        n = (c == 1) ? 4'h0 : 4'h3;
        check($sformatf("rd c%0d cmd dout", c), dout, {n, n});
        check($sformatf("rd c%0d cmd oe", c), oe, 1);
        check($sformatf("rd c%0d cmd sck", c), sck_en, 1);
        check($sformatf("rd c%0d cmd cs", c), cs_n, 0);
      end else if (c <= 8) begin
        n = 4'(c - 3);
        check($sformatf("rd c%0d addr dout", c), dout, {n, n});
        check($sformatf("rd c%0d addr oe", c), oe, 1);
        check($sformatf("rd c%0d addr cs", c), cs_n, 0);
      end else if (c <= 10) begin
        check($sformatf("rd c%0d dummy oe", c), oe, 0);
        check($sformatf("rd c%0d dummy dout", c), dout, 0);
        check($sformatf("rd c%0d dummy sck", c), sck_en, 1);
        check($sformatf("rd c%0d dummy vld", c), rd_vld, 0);
        check($sformatf("rd c%0d dummy cs", c), cs_n, 0);
      end else if (c <= 14 + stall_n) begin
        check($sformatf("rd c%0d data vld", c), rd_vld, 1);
        check($sformatf("rd c%0d data", c), rd_data, din);
        check($sformatf("rd c%0d data sck", c), sck_en, rd_rdy);
        check($sformatf("rd c%0d data cs", c), cs_n, 0);
        check($sformatf("rd c%0d data oe", c), oe, 0);
        check($sformatf("rd c%0d data wr_rdy", c), wr_rdy, 0);
        if (rd_rdy) beats++;
      end else if (c == 15 + stall_n) begin
        check($sformatf("rd c%0d end cs", c), cs_n, 1);
        check($sformatf("rd c%0d end sck", c), sck_en, 0);
        check($sformatf("rd c%0d end vld", c), rd_vld, 0);
        check($sformatf("rd c%0d end req_rdy", c), req_rdy, 0);
      end else begin
        check($sformatf("rd c%0d idle req_rdy", c), req_rdy, 1);
        check($sformatf("rd c%0d idle cs", c), cs_n, 1);
      end
    end
    check("rd beat count", beats, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] n;
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst cs", cs_n, 1);
      check("rst sck", sck_en, 0);
      check("rst oe", oe, 0);
      check("rst req_rdy", req_rdy, 0);
      check("rst dout", dout, 0);
    end
    rst = 0;
    #1;
    check("post-rst req_rdy", req_rdy, 1);
    check("post-rst req_rdy1", req_rdy1, 1);

    run_read(-1, 0);
    run_read(1, 3);

    // Write 0x000010, len 1, with wr_vld gaps; beats land in cycles 10 and 13.
    req_vld = 1; req_wr = 1; req_addr = 24'h000010; req_len = 8'd1;
    #1 check("wr c0 req_rdy", req_rdy, 1);
    for (int c = 1; c <= 15; c++) begin
      tick;
      req_vld = 0; wr_vld = 0; wr_data = 8'h00;
      if (c == 10) begin wr_vld = 1; wr_data = 8'hA5; end
      if (c == 13) begin wr_vld = 1; wr_data = 8'h3C; end
      #1;
      if (c <= 2) begin
        n = (c == 1) ? 4'h0 : 4'h2;
        check($sformatf("wr c%0d cmd dout", c), dout, {n, n});
      end else if (c <= 8) begin
        n = (c == 7) ? 4'h1 : 4'h0;
        check($sformatf("wr c%0d addr dout", c), dout, {n, n});
        check($sformatf("wr c%0d addr wr_rdy", c), wr_rdy, 0);
      end else if (c <= 13) begin
        check($sformatf("wr c%0d data oe", c), oe, 1);
        check($sformatf("wr c%0d data wr_rdy", c), wr_rdy, 1);
        check($sformatf("wr c%0d data rd_vld", c), rd_vld, 0);
        check($sformatf("wr c%0d data cs", c), cs_n, 0);
        check($sformatf("wr c%0d data sck", c), sck_en, (c == 10 || c == 13));
        check($sformatf("wr c%0d data dout", c), dout,
              (c == 10) ? 8'hA5 : (c == 13) ? 8'h3C : 8'h00);
      end else if (c == 14) begin
        check("wr end cs", cs_n, 1);
        check("wr end wr_rdy", wr_rdy, 0);
        check("wr end oe", oe, 0);
      end else begin
        check("wr idle req_rdy", req_rdy, 1);
      end
    end

    // Reset during the third read beat (cycle 13), then a full new read.
    req_vld = 1; req_wr = 0; req_addr = 24'h012345; req_len = 8'd3; rd_rdy = 1;
    for (int c = 1; c <= 13; c++) begin
      tick;
      req_vld = 0;
    end
    #1 check("mid c13 rd_vld", rd_vld, 1);
    rst = 1;
    tick;
    rst = 0;
    #1;
    check("mid after-rst cs", cs_n, 1);
    check("mid after-rst rd_vld", rd_vld, 0);
    check("mid after-rst sck", sck_en, 0);
    check("mid after-rst req_rdy", req_rdy, 1);
    run_read(-1, 0);

    // Single-memory build: write len 0, DATA right after ADDR in cycle 9.
    req_vld1 = 1; req_wr1 = 1; req_addr1 = 24'h000010; req_len1 = 8'd0;
    #1 check("sm c0 req_rdy", req_rdy1, 1);
    for (int c = 1; c <= 10; c++) begin
      tick;
      req_vld1 = 0;
      wr_vld1  = (c == 9);
      wr_data1 = (c == 9) ? 4'h9 : 4'h0;
      #1;
      if (c <= 9) check($sformatf("sm c%0d cs", c), cs_n1, 0);
      if (c == 2) check("sm c2 cmd dout", dout1, 4'h2);
      if (c == 7) check("sm c7 addr dout", dout1, 4'h1);
      if (c == 8) begin
        check("sm c8 oe", oe1, 1);
        check("sm c8 wr_rdy", wr_rdy1, 0);
      end
      if (c == 9) begin
        check("sm c9 wr_rdy", wr_rdy1, 1);
        check("sm c9 dout", dout1, 4'h9);
        check("sm c9 sck", sck_en1, 1);
        check("sm c9 oe", oe1, 1);
      end
      if (c == 10) begin
        check("sm c10 cs", cs_n1, 1);
        check("sm c10 wr_rdy", wr_rdy1, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
